// File: rtl/coin_btn_conditioner.sv
// Four-channel button conditioner: 2-flop sync, debounce, rise detect, per-channel
// press queue and prioritised single-cycle pulse emission. Optional macro: DBC_BYPASS_EN.
module coin_btn_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in1,
  input  logic btn_in2,
  input  logic btn_in5,
  input  logic btn_cancel,
  input  logic hold,
  output logic in1,
  output logic in2,
  output logic in5,
  output logic cancel,
  output logic ovf
);

  // Channel index doubles as priority rank: 3=cancel, 2=in5, 1=in2, 0=in1.
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] stable;
  logic [3:0] rise;
  logic [3:0] sel;
  logic [1:0] pend [4];

  assign raw = {btn_cancel, btn_in5, btn_in2, btn_in1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DBC_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
    end else begin
      stable <= sync2;
    end
  end

  assign rise = sync2 & ~stable;
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rise is flagged on the edge that accepts the new level, so the queue
  // is already loaded when stable first reads high.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      rise[i] = sync2[i] && !stable[i] && (cnt[i] == CNT_LAST);
    end
  end
`endif

  always_comb begin
    sel = '0;
    if (!hold) begin
      if (pend[3] != 2'd0) begin
        sel[3] = 1'b1;
      end else if (pend[2] != 2'd0) begin
        sel[2] = 1'b1;
      end else if (pend[1] != 2'd0) begin
        sel[1] = 1'b1;
      end else if (pend[0] != 2'd0) begin
        sel[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pend[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rise[i] && !sel[i]) begin
          if (pend[i] == 2'd3) begin
            ovf <= 1'b1;
          end else begin
            pend[i] <= pend[i] + 2'd1;
          end
        end else if (sel[i] && !rise[i]) begin
          pend[i] <= pend[i] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1    <= 1'b0;
      in2    <= 1'b0;
      in5    <= 1'b0;
      cancel <= 1'b0;
    end else begin
      in1    <= sel[0];
      in2    <= sel[1];
      in5    <= sel[2];
      cancel <= sel[3];
    end
  end

endmodule

// File: tb/tb_coin_btn_conditioner.sv
// Directed bench for coin_btn_conditioner with DB_CYCLES=4; DBC_BYPASS_EN selects
// the bypass-latency scenario instead of the debounce scenarios.
module tb_coin_btn_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in1 = 1'b0;
  logic btn_in2 = 1'b0;
  logic btn_in5 = 1'b0;
  logic btn_cancel = 1'b0;
  logic hold = 1'b0;
  logic in1, in2, in5, cancel, ovf;

  int n_cmp = 0;
  int n_err = 0;

  coin_btn_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_in1(btn_in1), .btn_in2(btn_in2), .btn_in5(btn_in5), .btn_cancel(btn_cancel),
    .hold(hold),
    .in1(in1), .in2(in2), .in5(in5), .cancel(cancel), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {cancel, in5, in2, in1};
  endfunction

  logic [3:0] w;
  int stray;

  initial begin
    step();
    step();
    chk("rst_outs", {28'd0, outs()}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

`ifdef DBC_BYPASS_EN
    // Single-cycle cancel glitch passes straight through: pulse after E3.
    btn_cancel = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) btn_cancel = 1'b0;
      w = outs();
      if (k == 3) chk("byp_cancel_e3", {28'd0, w}, 32'h8);
      else if (w != 4'd0) stray++;
    end
    chk("byp_stray", stray, 0);
    chk("byp_ovf", {31'd0, ovf}, 32'd0);
`else
    // 1: held in1 -> one pulse after E6.
    btn_in1 = 1'b1;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 19) btn_in1 = 1'b0;
      w = outs();
      if (k == 5) chk("t1_e5_quiet", {28'd0, w}, 32'h0);
      else if (k == 6) chk("t1_e6_pulse", {28'd0, w}, 32'h1);
      else if (k == 7) chk("t1_e7_quiet", {28'd0, w}, 32'h0);
      else if (w != 4'd0) stray++;
    end
    chk("t1_stray", stray, 0);

    // 2: bouncing in2 never settles -> nothing.
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      btn_in2 = (k < 10) ? ~btn_in2 : 1'b0;
      step();
      if (outs() != 4'd0) stray++;
    end
    chk("t2_no_pulse", stray, 0);
    chk("t2_ovf", {31'd0, ovf}, 32'd0);

    // 3: simultaneous in1/in5/cancel -> cancel, in5, in1.
    btn_in1 = 1'b1;
    btn_in5 = 1'b1;
    btn_cancel = 1'b1;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      w = outs();
      if (k == 6) chk("t3_cancel", {28'd0, w}, 32'h8);
      else if (k == 7) chk("t3_in5", {28'd0, w}, 32'h4);
      else if (k == 8) chk("t3_in1", {28'd0, w}, 32'h1);
      else if (w != 4'd0) stray++;
    end
    btn_in1 = 1'b0;
    btn_in5 = 1'b0;
    btn_cancel = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (outs() != 4'd0) stray++;
    end
    chk("t3_stray", stray, 0);

    // 4: four in2 presses under hold -> queue saturates at 3, fourth overflows.
    hold = 1'b1;
    stray = 0;
    for (int p = 0; p < 4; p++) begin
      if (p == 3) chk("t4_ovf_after3", {31'd0, ovf}, 32'd0);
      btn_in2 = 1'b1;
      for (int k = 0; k < 6; k++) begin
        step();
        if (outs() != 4'd0) stray++;
      end
      btn_in2 = 1'b0;
      for (int k = 0; k < 6; k++) begin
        step();
        if (outs() != 4'd0) stray++;
      end
    end
    chk("t4_hold_quiet", stray, 0);
    chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
    hold = 1'b0;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      w = outs();
      if (k < 3) chk("t4_in2_burst", {28'd0, w}, 32'h2);
      else if (w != 4'd0) stray++;
    end
    chk("t4_burst_len", stray, 0);
    chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

    // 5: reset mid-count clears immediately; fresh full latency afterwards.
    btn_in5 = 1'b1;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {28'd0, outs()}, 32'd0);
    chk("t5_rst_ovf", {31'd0, ovf}, 32'd0);
    step();
    step();
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      w = outs();
      if (k == 5) chk("t5_e5_quiet", {28'd0, w}, 32'h0);
      else if (k == 6) chk("t5_e6_in5", {28'd0, w}, 32'h4);
      else if (w != 4'd0) stray++;
    end
    chk("t5_stray", stray, 0);
    chk("t5_ovf", {31'd0, ovf}, 32'd0);
    btn_in5 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
